tdec_wrap_llr_pack: RTL and testbench

//  Upstream feeder of the de-ratematching stage: accepts a serial stream of 5-bit soft LLRs
//  and packs them 4-per-word into DIRAM (20-bit words) at a 5-bit-lane start offset.

---
 rtl/tdec_wrap_llr_pack_if.sv | 26 ++
 rtl/tdec_wrap_llr_pack.sv | 131 +++++++++++++
 tb/tb_tdec_wrap_llr_pack.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdec_wrap_llr_pack_if.sv
// LLR input stream and DIRAM write port of the LLR packer.
// master = packer side, slave = environment side.
interface tdec_wrap_llr_pack_if #(
    parameter int LLR_W  = 5,
    parameter int ADDR_W = 16
);
    logic                 llr_vld;
    logic                 llr_rdy;
    logic [LLR_W-1:0]     llr_data;
    logic                 llr_last;
    logic                 diram_wr_req;
    logic                 diram_wr_req_ack;
    logic [ADDR_W-1:0]    diram_wr_addr;
    logic [4*LLR_W-1:0]   diram_wr_data;
    logic [3:0]           diram_wr_mask;

    modport master (
        input  llr_vld, llr_data, llr_last, diram_wr_req_ack,
        output llr_rdy, diram_wr_req, diram_wr_addr, diram_wr_data, diram_wr_mask
    );

    modport slave (
        output llr_vld, llr_data, llr_last, diram_wr_req_ack,
        input  llr_rdy, diram_wr_req, diram_wr_addr, diram_wr_data, diram_wr_mask
    );
endinterface

// File: rtl/tdec_wrap_llr_pack.sv
// Packs serial 5-bit LLRs 4-per-word into masked DIRAM writes; last transfer -> done in 2 cycles with immediate ack.
// One staging entry; llr_rdy drops only when a word completes while the staged word is still unacked.
module tdec_wrap_llr_pack #(
    parameter int LLR_W  = 5,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 start,
    input  logic                 harq_cb_comb_mode,
    input  logic [ADDR_W+1:0]    base_addr,
    input  logic [16:0]          cb_len_m1,
    tdec_wrap_llr_pack_if.master bus,
    output logic                 done,
    output logic                 len_err
);
    localparam int WORD_W = 4 * LLR_W;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   stage_addr;
    logic [1:0]          lane;
    logic [WORD_W-1:0]   asm_dat;
    logic [WORD_W-1:0]   stage_dat;
    logic [WORD_W-1:0]   ins_dat;
    logic [WORD_W-1:0]   new_dat;
    logic [3:0]          asm_mask;
    logic [3:0]          stage_mask;
    logic [3:0]          lane_bit;
    logic [3:0]          new_mask;
    logic                stage_full;
    logic [17:0]         llr_cnt;
    logic [16:0]         len_q;
    logic                accept;
    logic                drop;
    logic                completes;
    logic                ack;

    // Lane 0 sits in the top bits, matching the DIRAM reader.
    always_comb begin
        ins_dat   = WORD_W'(bus.llr_data) << (LLR_W * (3 - int'(lane)));
        lane_bit  = 4'b1000 >> lane;
        drop      = llr_cnt > {1'b0, len_q};
        new_dat   = drop ? asm_dat : (asm_dat | ins_dat);
        new_mask  = drop ? asm_mask : (asm_mask | lane_bit);
        completes = ((lane == 2'd3) & ~drop) | bus.llr_last;
        ack       = stage_full & bus.diram_wr_req_ack;
    end

    assign bus.llr_rdy       = (state == S_FILL) & ~(stage_full & ~bus.diram_wr_req_ack & completes);
    assign accept            = bus.llr_vld & bus.llr_rdy;
    assign bus.diram_wr_req  = stage_full;
    assign bus.diram_wr_addr = stage_addr;
    assign bus.diram_wr_data = stage_dat;
    assign bus.diram_wr_mask = stage_mask;

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            state      <= S_IDLE;
            stage_full <= 1'b0;
            stage_addr <= '0;
            stage_dat  <= '0;
            stage_mask <= '0;
            asm_dat    <= '0;
            asm_mask   <= '0;
            llr_cnt    <= '0;
            len_q      <= '0;
            done       <= 1'b0;
            len_err    <= 1'b0;
            wr_addr    <= rst_n ? base_addr[ADDR_W+1:2] : '0;
            lane       <= rst_n ? base_addr[1:0] : 2'd0;
        end else begin
            done <= 1'b0;
            if (ack)
                stage_full <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FILL;
                        len_q    <= cb_len_m1;
                        llr_cnt  <= '0;
                        len_err  <= 1'b0;
                        asm_dat  <= '0;
                        asm_mask <= '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        llr_cnt <= llr_cnt + 18'd1;
                        if (drop || (bus.llr_last && llr_cnt != {1'b0, len_q}))
                            len_err <= 1'b1;
                        if (!drop)
                            lane <= lane + 2'd1;
                        if (completes) begin
                            asm_dat  <= '0;
                            asm_mask <= '0;
                            // An overflowing last LLR may leave nothing to write.
                            if (new_mask != 4'd0) begin
                                stage_full <= 1'b1;
                                stage_dat  <= new_dat;
                                stage_mask <= new_mask;
                                stage_addr <= wr_addr;
                            end
                            if (!drop && lane == 2'd3)
                                wr_addr <= wr_addr + ADDR_W'(1);
                        end else begin
                            asm_dat  <= new_dat;
                            asm_mask <= new_mask;
                        end
                        if (bus.llr_last)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!stage_full || ack) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (harq_cb_comb_mode) begin
                            wr_addr <= base_addr[ADDR_W+1:2];
                            lane    <= base_addr[1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdec_wrap_llr_pack.sv
// Scoreboard bench for the LLR packer: a bench-side packing model queues expected DIRAM writes.
module tb_tdec_wrap_llr_pack;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        start;
    logic        comb;
    logic [17:0] base_addr;
    logic [16:0] cb_len_m1;
    logic        done;
    logic        len_err;

    tdec_wrap_llr_pack_if #(.LLR_W(5), .ADDR_W(16)) bus ();

    tdec_wrap_llr_pack #(.LLR_W(5), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .init              (init),
        .start             (start),
        .harq_cb_comb_mode (comb),
        .base_addr         (base_addr),
        .cb_len_m1         (cb_len_m1),
        .bus               (bus),
        .done              (done),
        .len_err           (len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [19:0] d;
        logic [3:0]  m;
    } wr_t;

    wr_t            exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             ack_dly = 0;
    logic [15:0]    m_addr;
    logic [1:0]     m_lane;
    logic [3:0][4:0] m_dat;
    logic [3:0]     m_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_push();
        exp_q.push_back('{m_addr, m_dat, m_mask});
        m_dat  = '0;
        m_mask = '0;
    endtask

    task automatic do_init(input logic [17:0] b);
        base_addr = b;
        init      = 1'b1;
        cyc();
        init      = 1'b0;
        m_addr    = b[17:2];
        m_lane    = b[1:0];
        m_dat     = '0;
        m_mask    = '0;
    endtask

    task automatic send_llr(input logic [4:0] v, input logic last, output int stl);
        int  n;
        bit  hs;
        bus.llr_vld  = 1'b1;
        bus.llr_data = v;
        bus.llr_last = last;
        stl = 0;
        hs  = 1'b0;
        n   = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            #1;
            hs = bus.llr_rdy;
            if (!hs) stl++;
            n++;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("llr_handshake_timeout", 32'(hs), 32'd1);
        bus.llr_vld  = 1'b0;
        bus.llr_last = 1'b0;
    endtask

    // Drives one code block of n LLRs (values v0, v0+1, ...) and models the expected writes.
    task automatic run_cb(input int n, input int len_m1, input int v0, input bit do_last,
                          output int stalls, output int lat);
        int s;
        logic [4:0] v;
        stalls    = 0;
        lat       = 0;
        cb_len_m1 = 17'(len_m1);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = 5'(v0 + i);
            if (i <= len_m1) begin
                m_dat[3 - int'(m_lane)]  = v;
                m_mask[3 - int'(m_lane)] = 1'b1;
                if (m_lane == 2'd3) begin
                    m_push();
                    m_addr = m_addr + 16'd1;
                end
                m_lane = m_lane + 2'd1;
            end
            if (do_last && i == n - 1 && m_mask != 4'd0) m_push();
            send_llr(v, do_last && (i == n - 1), s);
            stalls += s;
        end
        if (do_last) begin
            do begin
                @(negedge clk);
                lat++;
            end while (!done && lat < 300);
            if (!done) chk("done_timeout", 32'(done), 32'd1);
            chk("len_err", 32'(len_err), 32'((n - 1) != len_m1));
            chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
            if (comb) begin
                m_addr = base_addr[17:2];
                m_lane = base_addr[1:0];
            end
            cyc();
        end
    endtask

    // DIRAM side: acks after ack_dly cycles of req and scores each write before its edge.
    initial begin
        int  wcnt;
        wr_t e;
        wcnt = 0;
        bus.diram_wr_req_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.diram_wr_req) begin
                wcnt = 0;
                bus.diram_wr_req_ack = (ack_dly == 0);
            end else if (wcnt >= ack_dly) begin
                bus.diram_wr_req_ack = 1'b1;
                wcnt = 0;
                chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.diram_wr_addr), 32'(e.a));
                    chk("wr_data", 32'(bus.diram_wr_data), 32'(e.d));
                    chk("wr_mask", 32'(bus.diram_wr_mask), 32'(e.m));
                end
            end else begin
                bus.diram_wr_req_ack = 1'b0;
                wcnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int stl;
        int lat;
        rst_n = 1'b0; init = 1'b0; start = 1'b0; comb = 1'b0;
        base_addr = '0; cb_len_m1 = '0;
        bus.llr_vld = 1'b0; bus.llr_data = '0; bus.llr_last = 1'b0;
        m_addr = '0; m_lane = '0; m_dat = '0; m_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.diram_wr_req), 32'd0);
        chk("rst_rdy", 32'(bus.llr_rdy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_addr", 32'(bus.diram_wr_addr), 32'd0);
        chk("rst_mask", 32'(bus.diram_wr_mask), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Two full words, immediate ack, done two cycles after the last transfer.
        do_init(18'h0);
        run_cb(8, 7, 1, 1'b1, stl, lat);
        chk("t1_done_latency", 32'(lat), 32'd2);
        chk("t1_stalls", 32'(stl), 32'd0);

        // Start mid-word at word1 lane2.
        do_init(18'h6);
        run_cb(3, 2, 10, 1'b1, stl, lat);

        // Back-to-back CBs share a word when not in combining mode.
        comb = 1'b0;
        do_init(18'h0);
        run_cb(5, 4, 16, 1'b1, stl, lat);
        run_cb(5, 4, 21, 1'b1, stl, lat);

        // Combining mode restarts each CB at base.
        comb = 1'b1;
        do_init(18'h0);
        run_cb(5, 4, 3, 1'b1, stl, lat);
        run_cb(5, 4, 9, 1'b1, stl, lat);
        comb = 1'b0;

        // Slow ack throttles the stream without loss.
        ack_dly = 6;
        do_init(18'h0);
        run_cb(12, 11, 2, 1'b1, stl, lat);
        chk("t5_stall_seen", 32'(stl > 0), 32'd1);

        // Ack within 3 cycles keeps full rate.
        ack_dly = 3;
        do_init(18'h0);
        run_cb(16, 15, 7, 1'b1, stl, lat);
        chk("t6_full_rate", 32'(stl), 32'd0);
        ack_dly = 0;

        // Short CB (len_err, mask E) then overflow with extra LLR dropped.
        do_init(18'h0);
        run_cb(3, 3, 4, 1'b1, stl, lat);
        do_init(18'h0);
        run_cb(3, 1, 12, 1'b1, stl, lat);
        chk("t7_overflow_rdy", 32'(stl), 32'd0);

        // Reset mid-FILL with a write pending.
        ack_dly = 100;
        do_init(18'h0);
        run_cb(5, 15, 1, 1'b0, stl, lat);
        chk("t8_req_pending", 32'(bus.diram_wr_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t8_req_dropped", 32'(bus.diram_wr_req), 32'd0);
        chk("t8_done", 32'(done), 32'd0);
        chk("t8_idle_rdy", 32'(bus.llr_rdy), 32'd0);
        cyc();
        rst_n = 1'b1;
        exp_q.delete();
        m_addr = '0; m_lane = '0; m_dat = '0; m_mask = '0;
        ack_dly = 0;
        cyc();
        run_cb(4, 3, 20, 1'b1, stl, lat);
        chk("t8_done_latency", 32'(lat), 32'd2);

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
